// File: rtl/sprite_motion_pkg.sv
// Shared types and constants for sprite motion and the jump FSM.
// Key bit positions, screen bounds and the motion state encoding.
package sprite_motion_pkg;

  typedef enum logic [1:0] {
    STAND = 2'd0,
    WALK  = 2'd1,
    AIR   = 2'd2
  } motion_state_t;

  localparam int KEY_UP    = 0;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  // 640x480 screen with a 16-pixel sprite; y bottom is the ground line.
  localparam logic [9:0] SCR_X_MIN = 10'd0;
  localparam logic [9:0] SCR_X_MAX = 10'd623;
  localparam logic [9:0] SCR_Y_MIN = 10'd0;
  localparam logic [9:0] SCR_Y_MAX = 10'd368;

endpackage

// File: rtl/sat_add10.sv
// Position accumulate-with-clamp: pos + delta, saturated to [min_val, max_val].
// The sum is kept 12-bit signed so negative overshoot clamps instead of wrapping.
module sat_add10 (
  input  logic        [9:0]  pos,
  input  logic signed [11:0] delta,
  input  logic        [9:0]  min_val,
  input  logic        [9:0]  max_val,
  output logic        [9:0]  result
);

  logic signed [11:0] sum;

  assign sum = $signed({2'b00, pos}) + delta;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves result unassigned (which would infer a latch).
    result = sum[9:0];
    if (sum < $signed({2'b00, min_val})) begin
      result = min_val;
    end else if (sum > $signed({2'b00, max_val})) begin
      result = max_val;
    end
  end

endmodule

// File: rtl/sprite_motion.sv
// Per-frame sprite integrator: applies walk steps and jump deltas to the
// registered position, and tracks facing and walk-cycle animation frame.
module sprite_motion
  import sprite_motion_pkg::*;
#(
  parameter logic [9:0] X_INIT   = 10'd100,
  parameter logic [9:0] Y_INIT   = 10'd368,
  parameter logic [9:0] X_MIN    = SCR_X_MIN,
  parameter logic [9:0] X_MAX    = SCR_X_MAX,
  parameter logic [9:0] Y_MIN    = SCR_Y_MIN,
  parameter logic [9:0] Y_MAX    = SCR_Y_MAX,
  parameter int         X_STEP   = 2,
  parameter int         ANIM_DIV = 4
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  input  logic [9:0]  up,
  input  logic [9:0]  down,
  input  logic        on_gnd,
  output logic [9:0]  sprite0xr,
  output logic [9:0]  sprite0yr,
  output logic        facing_left,
  output logic [1:0]  walk_frame,
  output logic [1:0]  motion_state
);

  localparam int             AW        = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [AW-1:0]  ANIM_LAST = AW'(ANIM_DIV - 1);

  logic               move_left, move_right;
  logic signed [11:0] x_delta, y_delta;
  logic        [9:0]  x_q, y_q, x_next, y_next;
  logic               facing_q;
  logic [AW-1:0]      anim_cnt;
  logic [1:0]         walk_frame_q;
  logic               anim_step, anim_clear;
  motion_state_t      state_q, state_d;
  logic               unused_keys;

  // Pressing both directions cancels out.
  assign move_left   = keycode[KEY_LEFT]  & ~keycode[KEY_RIGHT];
  assign move_right  = keycode[KEY_RIGHT] & ~keycode[KEY_LEFT];
  assign unused_keys = ^{keycode[15:4], keycode[1:0]};

  always_comb begin
    x_delta = '0;
    if (move_right) begin
      x_delta = 12'(X_STEP);
    end else if (move_left) begin
      x_delta = -12'(X_STEP);
    end
  end

  assign y_delta = {{2{up[9]}}, up} + {{2{down[9]}}, down};

  sat_add10 u_sat_x (
    .pos     (x_q),
    .delta   (x_delta),
    .min_val (X_MIN),
    .max_val (X_MAX),
    .result  (x_next)
  );

  sat_add10 u_sat_y (
    .pos     (y_q),
    .delta   (y_delta),
    .min_val (Y_MIN),
    .max_val (Y_MAX),
    .result  (y_next)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (Reset) begin
      state_q <= STAND;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = STAND;
    case (state_q)
      STAND, WALK, AIR: begin
        if (!on_gnd) begin
          state_d = AIR;
        end else if (move_left || move_right) begin
          state_d = WALK;
        end else begin
          state_d = STAND;
        end
      end
      default: state_d = STAND;
    endcase
  end

  // Animation follows the state being entered; AIR freezes the walk cycle.
  always_comb begin
    anim_step  = 1'b0;
    anim_clear = 1'b0;
    case (state_d)
      WALK:    anim_step  = 1'b1;
      STAND:   anim_clear = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      x_q      <= X_INIT;
      y_q      <= Y_INIT;
      facing_q <= 1'b0;
    end else begin
      x_q <= x_next;
      y_q <= y_next;
      if (move_left) begin
        facing_q <= 1'b1;
      end else if (move_right) begin
        facing_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      anim_cnt     <= '0;
      walk_frame_q <= 2'd0;
    end else if (anim_clear) begin
      anim_cnt     <= '0;
      walk_frame_q <= 2'd0;
    end else if (anim_step) begin
      if (anim_cnt == ANIM_LAST) begin
        anim_cnt     <= '0;
        walk_frame_q <= walk_frame_q + 2'd1;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end

  assign sprite0xr    = x_q;
  assign sprite0yr    = y_q;
  assign facing_left  = facing_q;
  assign walk_frame   = walk_frame_q;
  assign motion_state = state_q;

endmodule

// File: doc/sprite_motion.md
Name: sprite_motion

Overview:
- Downstream consumer of the jump FSM's vertical offsets (up, down, on_gnd) and of the keyboard keycode.
- Integrates them once per frame into the registered sprite position (sprite0xr/sprite0yr), which feeds both the jump FSM and the sprite renderer.
- Also produces facing direction and a walk-cycle animation frame index for the renderer.

Parameters:
- X_INIT, 100, reset x position (pixels)
- Y_INIT, 368, reset y position (ground line)
- X_MIN, 0, left clamp bound
- X_MAX, 623, right clamp bound (640 minus 16-pixel sprite width, minus 1)
- Y_MIN, 0, top clamp bound
- Y_MAX, 368, bottom clamp bound (ground)
- X_STEP, 2, horizontal pixels per frame while walking
- ANIM_DIV, 4, frames per walk-animation step

Ports:
- frame_clk  in  1  frame-rate clock (vsync-derived); all state updates on its rising edge
- Reset  in  1  asynchronous, active-high reset
- keycode  in  16  key bitmap: bit0 up, bit2 left, bit3 right; other bits ignored
- up  in  10  signed two's-complement vertical delta from the jump FSM
- down  in  10  signed two's-complement vertical delta from the jump FSM
- on_gnd  in  1  sprite grounded, from the jump FSM
- sprite0xr  out  10  registered sprite x
- sprite0yr  out  10  registered sprite y
- facing_left  out  1  1 = sprite faces left
- walk_frame  out  2  animation frame index 0..3
- motion_state  out  2  current FSM state encoding, for debug and renderer

Behaviour:
- Reset (asynchronous, active-high, effective immediately, including mid-jump): sprite0xr=X_INIT, sprite0yr=Y_INIT, facing_left=0, walk_frame=0, motion_state=STAND, animation counter=0.
- All inputs are sampled on the rising edge of frame_clk. Outputs are registered, so latency is exactly one frame from input to position.
- Horizontal intent:
  - left = keycode[2] & ~keycode[3]
  - right = keycode[3] & ~keycode[2]
  - both or neither pressed = no horizontal motion
- X update:
  - right: x_next = x + X_STEP
  - left: x_next = x - X_STEP
  - Computed as 12-bit signed, then clamped to [X_MIN, X_MAX].
  - At a bound, x holds at the bound; no wrap-around.
- Y update:
  - y_next = y + sext(up) + sext(down), computed as 12-bit signed (both deltas sign-extended from 10 bits).
  - Clamped to [Y_MIN, Y_MAX]. A negative intermediate result clamps to Y_MIN.
  - up and down are both applied in the same frame if both are nonzero.
- facing_left:
  - Set to 1 on left, cleared to 0 on right, otherwise held.
  - Updates in every state, including AIR.
- FSM states (motion_state encoding):
  - STAND = 2'd0
  - WALK = 2'd1
  - AIR = 2'd2
  - 2'd3 is unused; it recovers to STAND on the next frame.
- FSM transitions, evaluated each frame using the sampled inputs:
  - any state with on_gnd=0 -> AIR
  - on_gnd=1 with left or right -> WALK
  - on_gnd=1 with no horizontal intent -> STAND
- Animation counter (width clog2(ANIM_DIV)):
  - In WALK it increments each frame. When it reaches ANIM_DIV-1 it returns to 0 and walk_frame increments (3 wraps to 0).
  - Entering STAND clears both the counter and walk_frame.
  - In AIR both the counter and walk_frame hold their values.
- Simultaneous events:
  - Clamping applies after both axes update in the same frame.
  - State transition and position update occur on the same edge.

Decomposition:
- Shared package: motion_state_t enum (STAND, WALK, AIR); key bit-index constants KEY_UP=0, KEY_LEFT=2, KEY_RIGHT=3; screen bound constants. The jump FSM uses the same key constants.
- One sub-module, sat_add10: a signed 10-bit accumulate-with-clamp used for both axes. Inputs are the current position, a 12-bit signed delta, and the min and max bounds; output is the clamped 10-bit result.

Test Plan:
- Reset pulse mid-walk (x=200) -> outputs immediately 100/368, facing_left=0, walk_frame=0, motion_state=0.
- keycode=0x0008 held 10 frames from reset, on_gnd=1 -> x=120, motion_state=WALK, walk_frame=2 (after 10 frames, ANIM_DIV=4), facing_left=0.
- x=2, keycode=0x0004 held 3 frames -> x=0, 0, 0, no wrap; facing_left=1.
- y=368, on_gnd=0, up=10'h3FA (-6) for 3 frames, then down=6 for 3 frames -> y=362, 356, 350, 356, 362, 368; motion_state=AIR throughout; walk_frame held.
- y=3, up=-6 -> y=0 (clamped). Then y=366, down=6 -> y=368 (clamped).
- keycode=0x000C (left and right together), on_gnd=1 -> x unchanged, motion_state=STAND, walk_frame cleared to 0, facing_left held.
